// File: rtl/switch_allocator_rr_pkg.sv
// Shared configuration for the switch allocator: default port counts and
// downstream buffer depth (the CREDITS default).
package switch_allocator_rr_pkg;

   localparam int unsigned N_DEFAULT = 5;   // input ports
   localparam int unsigned M_DEFAULT = 5;   // output ports, output 0 is local ejection
   localparam int unsigned BUF_DEPTH = 4;   // downstream buffer depth per output

endpackage : switch_allocator_rr_pkg

// File: rtl/switch_allocator_rr_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning from i_ptr upward with modulo-N wrap.
//   i_req   [N-1:0]  request per requester
//   i_ptr   [PW-1:0] highest-priority requester index (always < N)
//   o_grant [N-1:0]  one-hot grant, zero when nothing requests
module rr_arbiter #(
   parameter int unsigned N  = 5,
   parameter int unsigned PW = 3
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant
);

   // Rotating scan; the first hit wins.
   always_comb begin
      int unsigned v_idx;
      logic        v_found;
      o_grant = '0;
      v_found = 1'b0;
      v_idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         v_idx = 32'(i_ptr) + k;
         if (v_idx >= N) v_idx = v_idx - N;
         if (!v_found && i_req[v_idx[PW-1:0]]) begin
            o_grant[v_idx[PW-1:0]] = 1'b1;
            v_found                = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/switch_allocator_rr.sv
// Per-router switch allocator. Grants each output to at most one input per
// cycle by round-robin, gated by downstream credits; multicast requests are
// granted all-or-nothing. Grant path is combinational, state is registered.
//   clk, reset_n       clock, async active-low reset
//   i_output_req       per-input requested output vector
//   i_data_val         per-input packet valid
//   i_credit_return    per-output downstream slot freed
//   o_grant            per-input/per-output final grant
//   o_input_pop        per-input dequeue strobe
//   o_output_sel       per-output crossbar select (0 when idle)
//   o_output_val       per-output packet valid
//   o_credit_err       sticky credit overflow flag
module switch_allocator_rr
   import switch_allocator_rr_pkg::*;
#(
   parameter int unsigned N       = N_DEFAULT,
   parameter int unsigned M       = M_DEFAULT,
   parameter int unsigned CREDITS = BUF_DEPTH
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [0:N-1][0:M-1]              i_output_req,
   input  logic [0:N-1]                     i_data_val,
   input  logic [0:M-1]                     i_credit_return,
   output logic [0:N-1][0:M-1]              o_grant,
   output logic [0:N-1]                     o_input_pop,
   output logic [0:M-1][$clog2(N)-1:0]      o_output_sel,
   output logic [0:M-1]                     o_output_val,
   output logic                             o_credit_err
);

   localparam int unsigned PW = $clog2(N);
   localparam int unsigned CW = $clog2(CREDITS + 1);

   logic [0:M-1]         w_pick_t [N];   // tentative picks, indexed by input
   logic [N-1:0]         w_col    [M];   // final grants, indexed by output
   logic [0:N-1]         w_win;          // input won every output it asked for
   logic [0:N-1][0:M-1]  w_gnt;
   logic [0:M-1]         w_ovf;          // credit return at full count
   logic                 r_credit_err;

   // Per-output eligibility, arbitration, pointer and credit state.
   for (genvar gm = 0; gm < M; gm++) begin : g_out
      logic [N-1:0]  w_elig;
      logic [N-1:0]  w_pick;
      logic [PW-1:0] w_sel;
      logic [PW-1:0] w_ptr_nxt;
      logic [CW-1:0] w_cred_nxt;
      logic [PW-1:0] r_ptr;
      logic [CW-1:0] r_cred;

      for (genvar gi = 0; gi < N; gi++) begin : g_elig
         assign w_elig[gi]      = i_data_val[gi] & i_output_req[gi][gm] & (r_cred != '0);
         assign w_pick_t[gi][gm] = w_pick[gi];
         assign w_col[gm][gi]   = w_gnt[gi][gm];
      end

      rr_arbiter #(
         .N  (N),
         .PW (PW)
      ) u_arb (
         .i_req   (w_elig),
         .i_ptr   (r_ptr),
         .o_grant (w_pick)
      );

      // Select and next pointer from the (at most one) final grant.
      always_comb begin
         w_sel     = '0;
         w_ptr_nxt = r_ptr;
         for (int unsigned i = 0; i < N; i++) begin
            if (w_col[gm][i]) begin
               w_sel     = PW'(i);
               w_ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
            end
         end
      end

      // Credit counter: a send and a return in the same cycle cancel.
      always_comb begin
         w_cred_nxt = r_cred;
         w_ovf[gm]  = 1'b0;
         if (o_output_val[gm] && !i_credit_return[gm]) begin
            w_cred_nxt = r_cred - CW'(1);
         end else if (!o_output_val[gm] && i_credit_return[gm]) begin
            if (r_cred == CW'(CREDITS)) w_ovf[gm] = 1'b1;
            else                        w_cred_nxt = r_cred + CW'(1);
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_ptr  <= '0;
            r_cred <= CW'(CREDITS);
         end else begin
            r_ptr  <= w_ptr_nxt;
            r_cred <= w_cred_nxt;
         end
      end

      assign o_output_sel[gm] = w_sel;
      assign o_output_val[gm] = |w_col[gm];
   end

   // All-or-nothing filter: an input keeps its picks only if every requested
   // output picked it; an empty request never wins. Reset voids all grants.
   for (genvar gi = 0; gi < N; gi++) begin : g_in
      assign w_win[gi] = reset_n & i_data_val[gi] & (|i_output_req[gi])
                       & ~(|(i_output_req[gi] & ~w_pick_t[gi]));
      for (genvar gm = 0; gm < M; gm++) begin : g_gnt
         assign w_gnt[gi][gm] = w_win[gi] & i_output_req[gi][gm];
      end
      assign o_input_pop[gi] = |w_gnt[gi];
   end

   assign o_grant = w_gnt;

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_credit_err <= 1'b0;
      else          r_credit_err <= r_credit_err | (|w_ovf);
   end

   assign o_credit_err = r_credit_err;

endmodule : switch_allocator_rr
